// File: rtl/multicycle_control_if.sv
// Datapath/memory-side signal bundle for the multicycle MIPS control FSM.
// The controller uses the slave modport; the datapath/memory side uses master.
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  // Handshake: a memory access (FETCH, MEMRD, MEMWR) completes in the first
  // cycle the controller sits in that state with mem_ready=1; the controller
  // holds its address/enable outputs stable until then or until the wait
  // counter times out. mem_ready has no meaning in any other state.
  logic [5:0]       ins;
  logic             mem_ready;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             PCWriteCondNe;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             RegWrite;
  logic             ALUSrcA;
  logic             ImmZext;
  logic [1:0]       PCSrc;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [1:0]       RegDst;
  logic [1:0]       WbSel;
  logic [3:0]       ALUOpFinal;
  logic             illegal;
  logic             mem_err;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output ins, mem_ready,
    input  PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite,
           IRWrite, RegWrite, ALUSrcA, ImmZext, PCSrc, ALUSrcB, ALUOp,
           RegDst, WbSel, ALUOpFinal, illegal, mem_err, state, instr_count
  );

  modport slave (
    input  ins, mem_ready,
    output PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite,
           IRWrite, RegWrite, ALUSrcA, ImmZext, PCSrc, ALUSrcB, ALUOp,
           RegDst, WbSel, ALUOpFinal, illegal, mem_err, state, instr_count
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with memory wait timeout and retire counter.
// Define MC_CTRL_JAL_EN to add the JAL state and decode of opcode 000011.
module multicycle_control #(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_control_if.slave   bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_RTEXE  = 4'd7,
    S_RTWB   = 4'd8,
    S_BEQ    = 4'd9,
    S_BNE    = 4'd10,
    S_IEXE   = 4'd11,
    S_IWB    = 4'd12,
    S_JUMP   = 4'd13,
    S_JAL    = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CTRL_JAL_EN
  localparam logic [5:0] OP_JAL   = 6'b000011;
`endif

  localparam int              WW        = $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0]   WAIT_LAST = WW'(WAIT_MAX - 1);

  state_t           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             mem_state;
  logic             timeout;
  logic             retire;
  logic             illegal_op;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      wait_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      count_q <= count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    illegal_op = 1'b0;
    mem_state  = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    // The stall that would bring the counter to WAIT_MAX is the timeout cycle.
    timeout    = mem_state && !bus.mem_ready && (wait_q == WAIT_LAST);

    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ready)  state_d = S_DECODE;
        else if (timeout)   state_d = S_FETCH;
      end
      S_DECODE: begin
        op_d = bus.ins;
        case (bus.ins)
          OP_RTYPE:                          state_d = S_RTEXE;
          OP_LW, OP_SW:                      state_d = S_MEMADR;
          OP_BEQ:                            state_d = S_BEQ;
          OP_BNE:                            state_d = S_BNE;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IEXE;
          OP_J:                              state_d = S_JUMP;
`ifdef MC_CTRL_JAL_EN
          OP_JAL:                            state_d = S_JAL;
`endif
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (bus.mem_ready)  state_d = S_MEMWB;
        else if (timeout)   state_d = S_FETCH;
      end
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR: begin
        if (bus.mem_ready || timeout) state_d = S_FETCH;
      end
      S_RTEXE:  state_d = S_RTWB;
      S_RTWB:   state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      S_BNE:    state_d = S_FETCH;
      S_IEXE:   state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
`ifdef MC_CTRL_JAL_EN
      S_JAL:    state_d = S_FETCH;
`endif
      default:  state_d = S_IDLE;
    endcase

    retire = (state_q == S_MEMWB) || (state_q == S_RTWB) || (state_q == S_BEQ) ||
             (state_q == S_BNE) || (state_q == S_IWB) || (state_q == S_JUMP) ||
             (state_q == S_JAL) || ((state_q == S_MEMWR) && bus.mem_ready);

    // Counter only survives while stalled in the same memory state; any exit clears it.
    wait_d  = (mem_state && !bus.mem_ready && !timeout) ? wait_q + WW'(1) : '0;
    count_d = retire ? count_q + CNT_W'(1) : count_q;
  end

  // Output decode
  always_comb begin
    bus.PCWrite       = 1'b0;
    bus.PCWriteCond   = 1'b0;
    bus.PCWriteCondNe = 1'b0;
    bus.IorD          = 1'b0;
    bus.MemRead       = 1'b0;
    bus.MemWrite      = 1'b0;
    bus.IRWrite       = 1'b0;
    bus.RegWrite      = 1'b0;
    bus.ALUSrcA       = 1'b0;
    bus.ImmZext       = 1'b0;
    bus.PCSrc         = 2'b00;
    bus.ALUSrcB       = 2'b00;
    bus.ALUOp         = 2'b00;
    bus.RegDst        = 2'b00;
    bus.WbSel         = 2'b00;
    bus.ALUOpFinal    = 4'b0000;
    bus.illegal       = 1'b0;
    bus.mem_err       = timeout;

    case (state_q)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
      end
      S_DECODE: begin
        bus.ALUSrcB = 2'b11;
        bus.illegal = illegal_op;
      end
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      S_MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.WbSel    = 2'b01;
      end
      S_MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      S_RTEXE: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
      end
      S_RTWB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 2'b01;
      end
      S_BEQ, S_BNE: begin
        bus.ALUSrcA       = 1'b1;
        bus.ALUOp         = 2'b01;
        bus.PCSrc         = 2'b01;
        bus.PCWriteCond   = (state_q == S_BEQ);
        bus.PCWriteCondNe = (state_q == S_BNE);
      end
      S_IEXE, S_IWB: begin
        case (op_q)
          OP_ADDI: bus.ALUOpFinal = 4'b0010;
          OP_ORI:  bus.ALUOpFinal = 4'b0001;
          OP_SLTI: bus.ALUOpFinal = 4'b0111;
          default: bus.ALUOpFinal = 4'b0000;
        endcase
        if (state_q == S_IEXE) begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'b10;
          bus.ALUOp   = 2'b11;
          bus.ImmZext = (op_q == OP_ANDI) || (op_q == OP_ORI);
        end else begin
          bus.RegWrite = 1'b1;
        end
      end
      S_JUMP: begin
        bus.PCWrite = 1'b1;
        bus.PCSrc   = 2'b10;
      end
`ifdef MC_CTRL_JAL_EN
      S_JAL: begin
        bus.PCWrite  = 1'b1;
        bus.PCSrc    = 2'b10;
        bus.RegWrite = 1'b1;
        bus.RegDst   = 2'b10;
        bus.WbSel    = 2'b10;
      end
`endif
      default: ;
    endcase
  end

  assign bus.state       = state_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: opcode table runs, stall/timeout/reset corners,
// and a CNT_W=2 instance for counter wrap.
module tb_multicycle_control;
  localparam int CNT_W    = 32;
  localparam int WAIT_MAX = 15;

  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2b;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst2 = 1'b1;

  multicycle_control_if #(.CNT_W(CNT_W)) bus ();
  multicycle_control_if #(.CNT_W(2))     bus2 ();

  multicycle_control #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  multicycle_control #(.CNT_W(2), .WAIT_MAX(WAIT_MAX)) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2.slave)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [29:0] obs;
  assign obs = {bus.state, bus.PCWrite, bus.PCWriteCond, bus.PCWriteCondNe, bus.IorD,
                bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.ALUSrcA,
                bus.ImmZext, bus.PCSrc, bus.ALUSrcB, bus.ALUOp, bus.RegDst, bus.WbSel,
                bus.ALUOpFinal, bus.illegal, bus.mem_err};

  typedef struct {
    logic [5:0]  op;
    logic [19:0] path;   // expected states, first cycle in the low nibble
    int          len;
    int          inc;
  } vec_t;

  vec_t             vecs[$];
  logic [29:0]      exp_q[$];
  int               n_pass = 0;
  int               n_total = 0;
  logic [CNT_W-1:0] model_count = '0;

  function automatic logic legal_op(input logic [5:0] op);
    logic l;
    l = op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h0c, 6'h0d, 6'h0a, 6'h02};
`ifdef MC_CTRL_JAL_EN
    if (op == 6'h03) l = 1'b1;
`endif
    return l;
  endfunction

  function automatic logic [3:0] imm_alu(input logic [5:0] op);
    case (op)
      6'h08:   return 4'b0010;
      6'h0d:   return 4'b0001;
      6'h0a:   return 4'b0111;
      default: return 4'b0000;
    endcase
  endfunction

  // Expected outputs per state, written from the output table of the design description
  function automatic logic [29:0] exp_obs(input logic [3:0] st, input logic [5:0] op,
                                          input logic mr, input logic merr);
    logic pcw, pcc, pcn, iord, mrd, mwr, irw, rgw, asa, imz, ill, mer;
    logic [1:0] pcs, asb, aop, rdst, wb;
    logic [3:0] fin;
    {pcw, pcc, pcn, iord, mrd, mwr, irw, rgw, asa, imz, ill, mer} = '0;
    {pcs, asb, aop, rdst, wb} = '0;
    fin = 4'b0000;
    case (st)
      4'd1:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; mer = merr; end
      4'd2:  begin asb = 2'b11; ill = !legal_op(op); end
      4'd3:  begin asa = 1; asb = 2'b10; end
      4'd4:  begin mrd = 1; iord = 1; mer = merr; end
      4'd5:  begin rgw = 1; wb = 2'b01; end
      4'd6:  begin mwr = 1; iord = 1; mer = merr; end
      4'd7:  begin asa = 1; aop = 2'b10; end
      4'd8:  begin rgw = 1; rdst = 2'b01; end
      4'd9:  begin asa = 1; aop = 2'b01; pcs = 2'b01; pcc = 1; end
      4'd10: begin asa = 1; aop = 2'b01; pcs = 2'b01; pcn = 1; end
      4'd11: begin asa = 1; asb = 2'b10; aop = 2'b11; fin = imm_alu(op);
                   imz = (op == 6'h0c) || (op == 6'h0d); end
      4'd12: begin rgw = 1; fin = imm_alu(op); end
      4'd13: begin pcw = 1; pcs = 2'b10; end
      4'd14: begin pcw = 1; pcs = 2'b10; rgw = 1; rdst = 2'b10; wb = 2'b10; end
      default: ;
    endcase
    return {st, pcw, pcc, pcn, iord, mrd, mwr, irw, rgw, asa, imz,
            pcs, asb, aop, rdst, wb, fin, ill, mer};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // One clock: drive inputs after the falling edge, compare just after.
  // ins is only meaningful in DECODE; elsewhere it gets random noise.
  task automatic cycle(input logic [3:0] st, input logic [5:0] op,
                       input logic mr, input logic merr);
    logic [29:0] e;
    @(negedge clk);
    bus.mem_ready = mr;
    bus.ins       = (st == 4'd2) ? op : 6'($urandom_range(0, 63));
    #1;
    exp_q.push_back(exp_obs(st, op, mr, merr));
    e = exp_q.pop_front();
    check($sformatf("obs st%0d op%h", st, op), 64'(obs), 64'(e));
  endtask

  task automatic chk_count();
    @(posedge clk);
    #1;
    check("instr_count", 64'(bus.instr_count), 64'(model_count));
  endtask

  task automatic run_vec(input int i);
    logic [19:0] p;
    p = vecs[i].path;
    for (int k = 0; k < vecs[i].len; k++)
      cycle(p[4*k +: 4], vecs[i].op, 1'b1, 1'b0);
    model_count = model_count + CNT_W'(vecs[i].inc);
    chk_count();
  endtask

  initial begin
    vecs.push_back('{6'h00, 20'h08721, 4, 1});  // R-type
    vecs.push_back('{6'h23, 20'h54321, 5, 1});  // lw
    vecs.push_back('{6'h2b, 20'h06321, 4, 1});  // sw
    vecs.push_back('{6'h04, 20'h00921, 3, 1});  // beq
    vecs.push_back('{6'h05, 20'h00A21, 3, 1});  // bne
    vecs.push_back('{6'h08, 20'h0CB21, 4, 1});  // addi
    vecs.push_back('{6'h0c, 20'h0CB21, 4, 1});  // andi
    vecs.push_back('{6'h0a, 20'h0CB21, 4, 1});  // slti
    vecs.push_back('{6'h0d, 20'h0CB21, 4, 1});  // ori
    vecs.push_back('{6'h02, 20'h00D21, 3, 1});  // j
    vecs.push_back('{6'h3f, 20'h00021, 2, 0});  // illegal
`ifdef MC_CTRL_JAL_EN
    vecs.push_back('{6'h03, 20'h00E21, 3, 1});  // jal
`else
    vecs.push_back('{6'h03, 20'h00021, 2, 0});  // jal disabled: illegal
`endif

    bus.ins = '0;  bus.mem_ready = 1'b0;
    bus2.ins = 6'h02; bus2.mem_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset obs", 64'(obs), 64'(0));
    check("reset instr_count", 64'(bus.instr_count), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    cycle(4'd0, 6'h00, 1'b1, 1'b0);  // the single IDLE cycle

    for (int i = 0; i < vecs.size(); i++) run_vec(i);

    // lw with three stalled MEMRD cycles
    cycle(4'd1, OP_LW, 1'b1, 1'b0);
    cycle(4'd2, OP_LW, 1'b1, 1'b0);
    cycle(4'd3, OP_LW, 1'b1, 1'b0);
    for (int w = 0; w < 3; w++) cycle(4'd4, OP_LW, 1'b0, 1'b0);
    cycle(4'd4, OP_LW, 1'b1, 1'b0);
    cycle(4'd5, OP_LW, 1'b1, 1'b0);
    model_count++;
    chk_count();

    // sw with mem_ready stuck low: timeout on the WAIT_MAX-th stalled cycle
    cycle(4'd1, OP_SW, 1'b1, 1'b0);
    cycle(4'd2, OP_SW, 1'b1, 1'b0);
    cycle(4'd3, OP_SW, 1'b1, 1'b0);
    for (int w = 1; w <= WAIT_MAX; w++) cycle(4'd6, OP_SW, 1'b0, w == WAIT_MAX);
    chk_count();

    // sw where mem_ready lands on the timeout cycle: completes normally
    cycle(4'd1, OP_SW, 1'b1, 1'b0);
    cycle(4'd2, OP_SW, 1'b1, 1'b0);
    cycle(4'd3, OP_SW, 1'b1, 1'b0);
    for (int w = 1; w < WAIT_MAX; w++) cycle(4'd6, OP_SW, 1'b0, 1'b0);
    cycle(4'd6, OP_SW, 1'b1, 1'b0);
    model_count++;
    chk_count();

    // asynchronous reset in the middle of MEMWR
    cycle(4'd1, OP_SW, 1'b1, 1'b0);
    cycle(4'd2, OP_SW, 1'b1, 1'b0);
    cycle(4'd3, OP_SW, 1'b1, 1'b0);
    cycle(4'd6, OP_SW, 1'b0, 1'b0);
    cycle(4'd6, OP_SW, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("rst mid state", 64'(bus.state), 64'(0));
    check("rst mid MemWrite", 64'(bus.MemWrite), 64'(0));
    check("rst mid instr_count", 64'(bus.instr_count), 64'(0));
    model_count = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    cycle(4'd0, 6'h00, 1'b1, 1'b0);
    run_vec(0);

    // CNT_W=2 instance: five jumps wrap the counter to 1
    @(posedge clk);
    #1 rst2 = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    check("cnt2 after 4 jumps", 64'(bus2.instr_count), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    check("cnt2 after 5 jumps", 64'(bus2.instr_count), 64'(1));
    check("cnt2 state", 64'(bus2.state), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle MIPS control FSM that replaces the single-opcode-decode control unit in the datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives every datapath select and enable from the current state. It waits on a memory ready handshake with a bounded timeout, flags illegal opcodes, and counts retired instructions. It sits between the instruction register and the shared multicycle datapath and memory port.

## Interface
- `CNT_W`, 32: width of the retired-instruction counter.
- `WAIT_MAX`, 15: maximum number of stall cycles per memory access before abort; must be ≥1.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset; asynchronous, active-high.
- `ins` in 6: opcode field of the instruction register.
- `mem_ready` in 1: memory completes the current access this cycle.
- `PCWrite`, `PCWriteCond`, `PCWriteCondNe`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `RegWrite`, `ALUSrcA`, `ImmZext` out 1: datapath enables and selects.
- `PCSrc`, `ALUSrcB`, `ALUOp`, `RegDst`, `WbSel` out 2: datapath selects. WbSel: 00 = ALU, 01 = memory, 10 = PC.
- `ALUOpFinal` out 4: ALU control for I-type ops. Codes: 0010 add, 0000 and, 0001 or, 0111 slt.
- `illegal` out 1: one-cycle pulse for an unknown opcode.
- `mem_err` out 1: one-cycle pulse when a memory access times out.
- `state` out 4: current state, for debug.
- `instr_count` out CNT_W: number of retired instructions.

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, RTEXE=7, RTWB=8, BEQ=9, BNE=10, IEXE=11, IWB=12, JUMP=13, JAL=14.
- Outputs are Moore-decoded from `state`, except the FETCH enables, which are gated by `mem_ready`. Every output not listed for a state is 0.
- IDLE: all outputs 0. Next state is FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00. IRWrite and PCWrite equal `mem_ready`.
  - Stays in FETCH until `mem_ready`, then goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Latches `ins` into an internal opcode register `op_q`. Next state by opcode:
  - 000000 → RTEXE.
  - 100011 (lw) and 101011 (sw) → MEMADR.
  - 000100 → BEQ; 000101 → BNE.
  - 001000 / 001100 / 001101 / 001010 → IEXE.
  - 000010 → JUMP; 000011 → JAL (see Configuration).
  - Any other opcode: `illegal`=1 this cycle, next state FETCH, not counted.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state MEMRD if `op_q` is lw, else MEMWR.
- MEMRD: MemRead=1, IorD=1. Holds until `mem_ready`, then MEMWB.
- MEMWB: RegWrite=1, RegDst=00, WbSel=01.
- MEMWR: MemWrite=1, IorD=1. Holds until `mem_ready`, then FETCH.
- RTEXE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state RTWB.
- RTWB: RegWrite=1, RegDst=01, WbSel=00.
- BEQ and BNE: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01. BEQ drives PCWriteCond=1; BNE drives PCWriteCondNe=1.
- IEXE: ALUSrcA=1, ALUSrcB=10, ALUOp=11. ALUOpFinal comes from `op_q`: addi 0010, andi 0000, ori 0001, slti 0111. ImmZext=1 for andi and ori. Next state IWB.
- IWB: RegWrite=1, RegDst=00, WbSel=00. ALUOpFinal is held from IEXE.
- JUMP: PCWrite=1, PCSrc=10.
- Completion states are MEMWB, MEMWR (on `mem_ready`), RTWB, BEQ, BNE, IWB, JUMP and JAL.
  - Each returns to FETCH and increments `instr_count` by 1.
  - `instr_count` wraps modulo 2^CNT_W.
- Memory wait counter:
  - Cleared on entry to FETCH, MEMRD or MEMWR.
  - Increments each cycle `mem_ready`=0 in those states.
  - If it reaches WAIT_MAX with `mem_ready` still 0: `mem_err`=1 for one cycle, next state FETCH, no count increment, no IRWrite, PCWrite, RegWrite or MemWrite side effect beyond the stalled cycles.
  - `mem_ready` arriving in the same cycle as the timeout wins: normal completion, no `mem_err`.

## Timing
- Reset (asserted asynchronously): state=IDLE, `op_q`=0, wait counter=0, `instr_count`=0, and all outputs 0. ALUOpFinal=0000.
- First FETCH is in the second rising edge after `rst` deasserts, i.e. one IDLE cycle.
- Cycle counts with `mem_ready` held at 1, counted from FETCH inclusive:
  - R-type: 4.
  - lw: 5.
  - sw: 4.
  - beq, bne, j: 3.
  - I-type ALU: 4.
  - jal: 3.
- Each cycle `mem_ready` is low adds one cycle.
- `ins` is sampled only in DECODE; changes at any other time are ignored.
- `rst` mid-instruction aborts immediately, with no further write enables asserted.

## Configuration
- `MC_CTRL_JAL_EN` defined: opcode 000011 goes to JAL. JAL drives PCWrite=1, PCSrc=10, RegWrite=1, RegDst=10 (selects $31) and WbSel=10.
- `MC_CTRL_JAL_EN` undefined: the JAL state and its decode are removed; opcode 000011 is illegal (`illegal` pulse, return to FETCH).

## Test plan
- `rst` pulse, then R-type 000000 with `mem_ready`=1: states 0,1,2,7,8,1. RegWrite=1 only in RTWB, RegDst=01. `instr_count`=1.
- lw with `mem_ready` low for 3 cycles in MEMRD: MEMRD lasts 4 cycles, then MEMWB with WbSel=01 and RegWrite=1. `mem_err`=0.
- sw with `mem_ready` stuck low, WAIT_MAX=15: `mem_err` pulses once, FETCH follows, `instr_count` unchanged, MemWrite deasserts.
- andi then slti: ALUOpFinal 0000 with ImmZext=1, then 0111 with ImmZext=0. Each lasts 4 cycles. `instr_count` increments by 2.
- Opcode 111111: `illegal`=1 in DECODE only, next state FETCH, no write enables. Opcode 000011 behaves as JAL or as illegal, per `MC_CTRL_JAL_EN`.
- `rst` asserted during MEMWR: state=0 and MemWrite=0 immediately. With CNT_W=2, 5 jumps leave `instr_count`=1.
